shift_deser: RTL and testbench

- Serial-to-parallel receiver; the receive end of the serial link driven by the team's parallel-load shift register.
- Collects N serial bits, strobed by `ser_valid`, into a shift register.
- Transfers each completed word into a separate holding register and presents it with a valid/ready handshake, so the next frame can be received while the consumer stalls.

---
 rtl/shift_deser_pkg.sv | 14 +
 rtl/shift_deser_bit_counter.sv | 23 ++
 rtl/shift_deser.sv | 135 +++++++++++++
 tb/tb_shift_deser.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deser_pkg.sv
// shift_deser_pkg: shared constants for the serial-to-parallel receiver.
//   state_t          : FSM encoding (ST_IDLE = 0, ST_RECV = 1)
//   ORDER_*_FIRST    : values of the latched bit-order flag
package shift_deser_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic ORDER_LSB_FIRST = 1'b0;
  localparam logic ORDER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser_bit_counter.sv
// bit_counter: frame bit counter for shift_deser.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-low
//   clr   : return count to 0 (wins over en)
//   en    : increment count
//   count : current count, W bits
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst)      count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + W'(1);
  end

endmodule

// File: rtl/shift_deser.sv
// shift_deser: serial-to-parallel receiver with a valid/ready holding register.
// Collects N bits strobed by ser_valid after a start pulse, then moves the
// completed word into data_out so the next frame can be received while the
// consumer stalls.
// Ports:
//   clk, rst (sync, active-low)
//   start, shift_type        : begin frame / bit order (0 LSB-first, 1 MSB-first)
//   ser_in, ser_valid        : serial bit and its strobe
//   data_ready, clr_ovr      : consumer accept / clear sticky overrun
//   data_out, data_valid     : received word and its valid flag
//   busy, overrun, par_err   : frame in progress / word dropped / parity error
// Build option: define SHIFT_DESER_PARITY_EN to expect one even-parity bit
// after the N data bits and report par_err; otherwise par_err is 0.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         shift_type,
  input  logic         ser_in,
  input  logic         ser_valid,
  input  logic         data_ready,
  input  logic         clr_ovr,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         busy,
  output logic         overrun,
  output logic         par_err
);

  localparam int CW = $clog2(N + 2);
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME_LEN = N + 1;
`else
  localparam int FRAME_LEN = N;
`endif

  state_t         state;
  logic           order;
  logic [N-1:0]   sreg;
  logic [N-1:0]   shifted;
  logic [N-1:0]   word_new;
  logic [CW-1:0]  cnt;
  logic           bit_acc;
  logic           last;
  logic           data_bit;
  logic           load;
  logic           drop;

  // start always wins over a coincident ser_valid, dropping that bit
  assign bit_acc  = (state == ST_RECV) && ser_valid && !start;
  assign last     = bit_acc && (cnt == CW'(FRAME_LEN - 1));
  // the parity bit (count == N) never enters the data register
  assign data_bit = bit_acc && (cnt < CW'(N));

  assign shifted = (order == ORDER_MSB_FIRST) ? {sreg[N-2:0], ser_in}
                                              : {ser_in, sreg[N-1:1]};

  // holding register frees up in the same cycle the consumer takes it
  assign load = last && (!data_valid || data_ready);
  assign drop = last && data_valid && !data_ready;
  assign busy = (state == ST_RECV);

`ifdef SHIFT_DESER_PARITY_EN
  logic par_new;
  logic par_q;
  // final strobe carries the parity bit; data is already complete in sreg
  assign word_new = sreg;
  assign par_new  = (^sreg) ^ ser_in;
  assign par_err  = par_q;

  always_ff @(posedge clk) begin
    if (!rst)      par_q <= 1'b0;
    else if (load) par_q <= par_new;
  end
`else
  assign word_new = shifted;
  assign par_err  = 1'b0;
`endif

  bit_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start || last),
    .en    (bit_acc),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      order      <= ORDER_LSB_FIRST;
      sreg       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RECV;
            order <= shift_type;
            sreg  <= '0;
          end
        end
        ST_RECV: begin
          if (start) begin
            // restart: discard the partial frame
            order <= shift_type;
            sreg  <= '0;
          end else begin
            if (data_bit) sreg  <= shifted;
            if (last)     state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (load) begin
        data_out   <= word_new;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      // a new drop wins over a coincident clear
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: directed bench for shift_deser (N = 8). Words accepted by
// the receiver are queued with their expected value; a monitor pops and
// compares on each data_valid && data_ready transfer. Status outputs are
// checked directly at fixed points.
module tb_shift_deser;

  localparam int N = 8;
`ifdef SHIFT_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] d;
    logic         p;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         shift_type = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         data_ready = 1'b0;
  logic         clr_ovr = 1'b0;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  logic         par_err;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_deser #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .shift_type (shift_type),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .data_ready (data_ready),
    .clr_ovr    (clr_ovr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compare every transfer against the scoreboard head
  always @(negedge clk) begin
    if (rst && data_valid && data_ready) begin
      exp_t e;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL xfer_unexpected: got data %0h with no expected word", data_out);
      end else begin
        e = q.pop_front();
        chk("xfer_data", 32'(data_out), 32'(e.d));
        chk("xfer_par", 32'(par_err), 32'(e.p));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic order);
    start      = 1'b1;
    shift_type = order;
    tick();
    start = 1'b0;
  endtask

  // seq[i] is the i-th bit on the wire; an even-parity bit (optionally
  // flipped) follows when parity is built in
  task automatic send_frame(input logic [N-1:0] seq, input logic flip, input logic ready_last);
    int nb;
    logic [N:0] bits;
    bits = {(^seq) ^ flip, seq};
    nb = PAR ? N + 1 : N;
    for (int i = 0; i < nb; i++) begin
      ser_valid = 1'b1;
      ser_in    = bits[i];
      if (i == nb - 1) data_ready = ready_last;
      tick();
    end
    ser_valid  = 1'b0;
    data_ready = 1'b0;
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    // reset
    rst = 1'b0;
    tick(); tick();
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_par", 32'(par_err), 32'h0);
    rst = 1'b1;
    tick();

    // ser_valid in IDLE is ignored
    ser_valid = 1'b1; ser_in = 1'b1;
    tick(); tick();
    ser_valid = 1'b0;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_valid", 32'(data_valid), 32'h0);

    // LSB-first 0x96; shift_type toggles mid-frame with no effect
    pulse_start(1'b0);
    chk("t1_busy", 32'(busy), 32'h1);
    shift_type = 1'b1;
    e.d = 8'h96; e.p = 1'b0; q.push_back(e);
    send_frame(8'h96, 1'b0, 1'b0);
    chk("t1_valid", 32'(data_valid), 32'h1);
    chk("t1_data", 32'(data_out), 32'h96);
    chk("t1_busy_done", 32'(busy), 32'h0);
    consume();
    chk("t1_valid_drop", 32'(data_valid), 32'h0);

    // MSB-first, same wire sequence -> 0x69
    pulse_start(1'b1);
    e.d = 8'h69; e.p = 1'b0; q.push_back(e);
    send_frame(8'h96, 1'b0, 1'b0);
    chk("t2_data", 32'(data_out), 32'h69);
    consume();

    // overrun: 0x96 held, 0x11 dropped
    pulse_start(1'b0);
    e.d = 8'h96; e.p = 1'b0; q.push_back(e);
    send_frame(8'h96, 1'b0, 1'b0);
    chk("t3_ovr_before", 32'(overrun), 32'h0);
    pulse_start(1'b0);
    send_frame(8'h11, 1'b0, 1'b0);
    chk("t3_data_kept", 32'(data_out), 32'h96);
    chk("t3_ovr", 32'(overrun), 32'h1);
    chk("t3_valid", 32'(data_valid), 32'h1);
    tick();
    chk("t3_ovr_sticky", 32'(overrun), 32'h1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t3_ovr_clr", 32'(overrun), 32'h0);
    consume();

    // consumer takes the held word as the next one completes
    pulse_start(1'b0);
    e.d = 8'h96; e.p = 1'b0; q.push_back(e);
    send_frame(8'h96, 1'b0, 1'b0);
    pulse_start(1'b0);
    e.d = 8'h11; e.p = 1'b0; q.push_back(e);
    send_frame(8'h11, 1'b0, 1'b1);
    chk("t4_data", 32'(data_out), 32'h11);
    chk("t4_valid", 32'(data_valid), 32'h1);
    chk("t4_ovr", 32'(overrun), 32'h0);
    consume();

    // restart after 3 bits; restart pulse carries a bit that must be dropped
    pulse_start(1'b0);
    ser_valid = 1'b1; ser_in = 1'b1;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0; ser_valid = 1'b0;
    chk("t5_busy", 32'(busy), 32'h1);
    e.d = 8'hF0; e.p = 1'b0; q.push_back(e);
    send_frame(8'hF0, 1'b0, 1'b0);
    chk("t5_data", 32'(data_out), 32'hF0);
    consume();

    // reset mid-frame with a pending word: everything is lost
    pulse_start(1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    pulse_start(1'b0);
    ser_valid = 1'b1; ser_in = 1'b1;
    tick(); tick(); tick(); tick();
    ser_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_data", 32'(data_out), 32'h0);
    chk("t6_valid", 32'(data_valid), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_ovr", 32'(overrun), 32'h0);
    pulse_start(1'b0);
    e.d = 8'h96; e.p = 1'b0; q.push_back(e);
    send_frame(8'h96, 1'b0, 1'b0);
    chk("t6_after", 32'(data_out), 32'h96);
    consume();

`ifdef SHIFT_DESER_PARITY_EN
    // bad parity bit
    pulse_start(1'b0);
    e.d = 8'h96; e.p = 1'b1; q.push_back(e);
    send_frame(8'h96, 1'b1, 1'b0);
    chk("t7_par", 32'(par_err), 32'h1);
    chk("t7_data", 32'(data_out), 32'h96);
    consume();
`endif

    tick(); tick();
    chk("sb_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
